obz_drive_seq: RTL and testbench

//  Upstream driver stage for a tristate output pad (OBZ-style buffer: O = I while T=0, high-Z while T=1).

---
 rtl/obz_drive_seq_pkg.sv | 19 +
 rtl/obz_drive_seq_shift_out.sv | 33 +++
 rtl/obz_drive_seq.sv | 158 +++++++++++++++
 tb/tb_obz_drive_seq.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/obz_drive_seq_pkg.sv
// Shared state encoding and sizing helpers for the tristate pad driver sequencer.
package obz_drive_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_TRAIL = 3'd4
  } state_t;

  // The lead/trail counter only ever holds values up to max(lead, trail) - 1.
  function automatic int cnt_width(input int lead, input int trail);
    int m;
    m = (lead > trail) ? lead : trail;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/obz_drive_seq_shift_out.sv
// Load/shift register feeding the pad data bit; sout previews the word being loaded
// so a new word's first bit can leave on the same edge that loads it.
module obz_drive_seq_shift_out #(
  parameter int DW        = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          load,
  input  logic          shift,
  output logic          sout
);

  logic [DW-1:0] sr;
  logic [DW-1:0] src;

  always_comb begin
    src  = load ? din : sr;
    sout = (LSB_FIRST != 0) ? src[0] : src[DW-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (shift) begin
      sr <= (LSB_FIRST != 0) ? {1'b0, src[DW-1:1]} : {src[DW-2:0], 1'b0};
    end else if (load) begin
      sr <= din;
    end
  end

endmodule

// File: rtl/obz_drive_seq.sv
// Serialises handshaked words onto a tristate pad, wrapping each burst in driven
// lead/trail cycles and releasing the pad to high-Z between bursts.
//
//   state    | meaning
//   ST_IDLE  | pad released (high-Z), ready for the first word of a burst
//   ST_LEAD  | pad driven at idle level before the first data bit
//   ST_SHIFT | one data bit per cycle; next word accepted on the final bit
//   ST_HOLD  | mid-burst gap, pad held at idle level awaiting the next word
//   ST_TRAIL | pad driven at idle level after the last data bit
module obz_drive_seq
  import obz_drive_seq_pkg::*;
#(
  parameter int   DW        = 8,
  parameter int   LEAD_CYC  = 2,
  parameter int   TRAIL_CYC = 2,
  parameter int   LSB_FIRST = 1,
  parameter logic IDLE_LVL  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          dlast,
  input  logic          dvalid,
  output logic          dready,
  output logic          pad_i,
  output logic          pad_t,
  output logic          busy,
  output logic          done
);

  localparam int BW = $clog2(DW);
  localparam int CW = cnt_width(LEAD_CYC, TRAIL_CYC);
  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [BW-1:0] bit_cnt, bit_nx;
  logic          dlast_q, dlast_nx;
  logic          pad_i_nx, pad_t_nx, done_nx;
  logic          load, shift, sout, xfer;

  obz_drive_seq_shift_out #(
    .DW        (DW),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .load  (load),
    .shift (shift),
    .sout  (sout)
  );

  // Depends only on registered state, so there is no path from dvalid.
  always_comb begin
    dready = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE:  dready = 1'b1;
        ST_HOLD:  dready = 1'b1;
        ST_SHIFT: dready = (bit_cnt == LAST_BIT) && !dlast_q;
        default:  dready = 1'b0;
      endcase
    end
  end

  assign xfer = dvalid & dready;
  assign busy = (state != ST_IDLE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bit_nx   = bit_cnt;
    dlast_nx = dlast_q;
    load     = 1'b0;
    shift    = 1'b0;
    done_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (xfer) begin
          load     = 1'b1;
          dlast_nx = dlast;
          cnt_nx   = CW'(LEAD_CYC - 1);
          state_nx = ST_LEAD;
        end
      end
      ST_LEAD: begin
        if (cnt == '0) begin
          shift    = 1'b1;
          bit_nx   = '0;
          state_nx = ST_SHIFT;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      ST_SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          if (xfer) begin
            load     = 1'b1;
            shift    = 1'b1;
            dlast_nx = dlast;
            bit_nx   = '0;
          end else if (dlast_q) begin
            cnt_nx   = CW'(TRAIL_CYC - 1);
            state_nx = ST_TRAIL;
          end else begin
            state_nx = ST_HOLD;
          end
        end else begin
          shift  = 1'b1;
          bit_nx = bit_cnt + BW'(1);
        end
      end
      ST_HOLD: begin
        if (xfer) begin
          load     = 1'b1;
          shift    = 1'b1;
          dlast_nx = dlast;
          bit_nx   = '0;
          state_nx = ST_SHIFT;
        end
      end
      ST_TRAIL: begin
        if (cnt == '0) begin
          done_nx  = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    // Pad outputs reflect the state being entered; a bit leaves whenever the shifter advances.
    pad_t_nx = (state_nx == ST_IDLE);
    pad_i_nx = shift ? sout : IDLE_LVL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      dlast_q <= 1'b0;
      pad_i   <= IDLE_LVL;
      pad_t   <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_cnt <= bit_nx;
      dlast_q <= dlast_nx;
      pad_i   <= pad_i_nx;
      pad_t   <= pad_t_nx;
      done    <= done_nx;
    end
  end

endmodule

// File: tb/tb_obz_drive_seq.sv
// Randomised bench for obz_drive_seq: a per-cycle timeline model of the expected pad
// waveform, plus a directed MSB-first word on a second instance.
module tb_obz_drive_seq;

  localparam int   DW    = 8;
  localparam int   LEAD  = 2;
  localparam int   TRAIL = 2;
  localparam logic IDLE  = 1'b1;

  logic          clk = 1'b0;
  logic          rst, dlast, dvalid, dready, pad_i, pad_t, busy, done;
  logic [DW-1:0] din;
  logic          rst1, dlast1, dvalid1, dready1, pad_i1, pad_t1, busy1, done1;
  logic [DW-1:0] din1;

  always #5 clk = ~clk;

  obz_drive_seq #(.DW(DW), .LEAD_CYC(LEAD), .TRAIL_CYC(TRAIL), .LSB_FIRST(1), .IDLE_LVL(IDLE)) u0 (
    .clk(clk), .rst(rst), .din(din), .dlast(dlast), .dvalid(dvalid), .dready(dready),
    .pad_i(pad_i), .pad_t(pad_t), .busy(busy), .done(done)
  );

  obz_drive_seq #(.DW(DW), .LEAD_CYC(LEAD), .TRAIL_CYC(TRAIL), .LSB_FIRST(0), .IDLE_LVL(IDLE)) u1 (
    .clk(clk), .rst(rst1), .din(din1), .dlast(dlast1), .dvalid(dvalid1), .dready(dready1),
    .pad_i(pad_i1), .pad_t(pad_t1), .busy(busy1), .done(done1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected pad behaviour, one entry per future cycle.
  typedef struct packed {
    logic t;
    logic i;
    logic d;
  } pad_s;

  pad_s exp_q[$];
  pad_s cur;
  bit   open_burst;

  function automatic logic model_ready();
    if (cur.t) return 1'b1;
    return open_burst && (exp_q.size() == 0);
  endfunction

  task automatic step(input logic r, input logic v, input logic [DW-1:0] w, input logic l);
    logic exp_rdy, x;
    chk("pad_t", 32'(pad_t), 32'(cur.t));
    chk("pad_i", 32'(pad_i), 32'(cur.i));
    chk("done",  32'(done),  32'(cur.d));
    chk("busy",  32'(busy),  32'(!cur.t));
    rst = r; dvalid = v; din = w; dlast = l;
    #1;
    exp_rdy = r ? 1'b0 : model_ready();
    chk("dready", 32'(dready), 32'(exp_rdy));
    x = v && exp_rdy;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      open_burst = 1'b0;
      cur = '{t: 1'b1, i: IDLE, d: 1'b0};
    end else begin
      if (x) begin
        if (cur.t) for (int k = 0; k < LEAD; k++) exp_q.push_back('{t: 1'b0, i: IDLE, d: 1'b0});
        for (int b = 0; b < DW; b++) exp_q.push_back('{t: 1'b0, i: w[b], d: 1'b0});
        open_burst = !l;
        if (l) begin
          for (int k = 0; k < TRAIL; k++) exp_q.push_back('{t: 1'b0, i: IDLE, d: 1'b0});
          exp_q.push_back('{t: 1'b1, i: IDLE, d: 1'b1});
        end
      end
      if (exp_q.size() != 0) cur = exp_q.pop_front();
      else if (open_burst)   cur = '{t: 1'b0, i: IDLE, d: 1'b0};
      else                   cur = '{t: 1'b1, i: IDLE, d: 1'b0};
    end
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] w1;
    rst = 1'b1; dvalid = 1'b0; din = '0; dlast = 1'b0;
    rst1 = 1'b1; dvalid1 = 1'b0; din1 = '0; dlast1 = 1'b0;
    open_burst = 1'b0;
    cur = '{t: 1'b1, i: IDLE, d: 1'b0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pad_t", 32'(pad_t), 32'd1);
    chk("rst_pad_i", 32'(pad_i), 32'(IDLE));
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dready", 32'(dready), 32'd0);

    // Single word, then back-to-back with dvalid held (stall), then a hold gap.
    step(1'b0, 1'b1, 8'hA5, 1'b1);
    repeat (14) step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h0F, 1'b0);
    repeat (12) step(1'b0, 1'b1, 8'hF0, 1'b1);
    repeat (12) step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h01, 1'b0);
    repeat (14) step(1'b0, 1'b0, 8'h3C, 1'b0);
    step(1'b0, 1'b1, 8'hC3, 1'b1);
    repeat (14) step(1'b0, 1'b0, 8'h00, 1'b0);
    // Reset mid-burst.
    step(1'b0, 1'b1, 8'h96, 1'b1);
    repeat (5) step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b0);
    repeat (4) step(1'b0, 1'b0, 8'h00, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 6),
           DW'($urandom), ($urandom_range(0, 9) < 3));
    end
    repeat (60) step(1'b0, 1'b0, 8'h00, 1'b0);

    // MSB-first instance: 8'h80 gives a 1 followed by seven 0s.
    w1 = 8'h80;
    rst1 = 1'b0; dvalid1 = 1'b1; din1 = w1; dlast1 = 1'b1;
    #1;
    chk("u1_dready", 32'(dready1), 32'd1);
    @(posedge clk);
    @(negedge clk);
    dvalid1 = 1'b0; din1 = 8'h7F;
    for (int k = 1; k <= 13; k++) begin
      chk("u1_pad_t", 32'(pad_t1), 32'(k == 13));
      chk("u1_pad_i", 32'(pad_i1), 32'((k >= 3 && k <= 10) ? w1[7 - (k - 3)] : IDLE));
      chk("u1_done",  32'(done1),  32'(k == 13));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
